// File: rtl/memory_unit_if.sv
// Control-unit to memory-unit bus: command decode inputs, the shared bus, and the host preload port.
interface memory_unit_if;
  logic [2:0] memory_op;
  logic       data_word_selector;
  logic       bus_selector;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] pc;
  logic [7:0] mar;
  logic       op_error;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;

  modport master (
    output memory_op, data_word_selector, bus_selector, bus_in,
    output prog_we, prog_addr, prog_data,
    input  bus_out, bus_oe, pc, mar, op_error
  );

  modport slave (
    input  memory_op, data_word_selector, bus_selector, bus_in,
    input  prog_we, prog_addr, prog_data,
    output bus_out, bus_oe, pc, mar, op_error
  );
endinterface

// File: rtl/memory_unit.sv
// Memory unit: 256-byte program/data RAM with PC and MAR, executing control-unit bus commands.
// Read data is combinational; all register and RAM updates land on the rising clock edge.
package control;
  typedef enum logic [2:0] {
    MEM_NOP      = 3'd0,
    MEM_READ     = 3'd1,
    MEM_WRITE    = 3'd2,
    MEM_PC_INC   = 3'd3,
    MEM_PC_LOAD  = 3'd4,
    MEM_MAR_LOAD = 3'd5,
    MEM_FETCH    = 3'd6,
    MEM_RSVD     = 3'd7
  } memory_op_e;
endpackage

module memory_unit #(
  parameter int DEPTH = 256
) (
  input logic         clock,
  input logic         reset,
  memory_unit_if.slave mem
);
  import control::*;

  logic [7:0] ram [DEPTH];
  logic [7:0] pc_q;
  logic [7:0] mar_q;
  logic       err_q;
  logic [7:0] addr;
  memory_op_e op;
  logic       rd_en;
  logic       wr_en;
  logic       pc_inc;
  logic       pc_load;
  logic       mar_load;
  logic       illegal;

  assign op = memory_op_e'(mem.memory_op);

  always_comb begin
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    mar_load = 1'b0;
    illegal  = 1'b0;
    case (op)
      MEM_READ:     rd_en = 1'b1;
      MEM_FETCH: begin
        rd_en  = 1'b1;
        pc_inc = 1'b1;
      end
      // Writing while memory owns the bus would fight the read driver; refuse it.
      MEM_WRITE: begin
        if (mem.bus_selector) illegal = 1'b1;
        else                  wr_en   = 1'b1;
      end
      MEM_PC_INC:   pc_inc   = 1'b1;
      MEM_PC_LOAD:  pc_load  = 1'b1;
      MEM_MAR_LOAD: mar_load = 1'b1;
      MEM_RSVD:     illegal  = 1'b1;
      default:      ;
    endcase
  end

  assign addr = (op == MEM_FETCH || !mem.data_word_selector) ? pc_q : mar_q;

  // Output drive is gated by reset so the bus is released the instant reset asserts.
  assign mem.bus_oe  = rd_en & mem.bus_selector & ~reset;
  assign mem.bus_out = mem.bus_oe ? ram[addr] : 8'h00;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q  <= 8'h00;
      mar_q <= 8'h00;
      err_q <= 1'b0;
    end else begin
      if (pc_load)     pc_q  <= mem.bus_in;
      else if (pc_inc) pc_q  <= pc_q + 8'h01;
      if (mar_load)    mar_q <= mem.bus_in;
      if (illegal)     err_q <= 1'b1;
    end
  end

  // Preload is written last so it wins an address collision; it also works during reset.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) ram[addr] <= mem.bus_in;
    if (mem.prog_we)     ram[mem.prog_addr] <= mem.prog_data;
  end

  assign mem.pc       = pc_q;
  assign mem.mar      = mar_q;
  assign mem.op_error = err_q;
endmodule
